// File: rtl/fwd_bypass_unit_pkg.sv
// Shared definitions for the ID-stage operand bypass unit.
// Holds the stall-bus encoding, the ID/EX stall bit positions and the
// register-update mode decode used by the top level.
package fwd_bypass_unit_pkg;

  // Stall bus encoding: a set bit stops the corresponding pipeline stage.
  localparam logic        Stop       = 1'b1;
  localparam logic        NoStop     = 1'b0;
  localparam int unsigned StallBusW  = 6;
  localparam int unsigned StallIdIdx = 2;
  localparam int unsigned StallExIdx = 3;

  // How the per-port ID/EX register set is updated on the next clock edge.
  typedef enum logic [1:0] {
    UpdClear,    // reset, flush, or bubble inserted into EX
    UpdCapture,  // ID advances: take the new winner and latch the read request
    UpdHold      // ID and EX both stopped: keep, but refresh from retiring writes
  } upd_mode_e;

  // First matching case wins: rst, flush, bubble, advance, hold.
  function automatic upd_mode_e upd_mode(input logic rst, input logic flush,
                                         input logic stall_id, input logic stall_ex);
    upd_mode_e mode;
    if (rst || flush) begin
      mode = UpdClear;
    end else if (stall_id == Stop && stall_ex == NoStop) begin
      mode = UpdClear;
    end else if (stall_id == NoStop) begin
      mode = UpdCapture;
    end else begin
      mode = UpdHold;
    end
    return mode;
  endfunction

endpackage

// File: rtl/fwd_bypass_unit_port_sel.sv
// Per-read-port forwarding selector (module fwd_port_sel).
// Compares one read address against every producer stage and picks the
// youngest (lowest index) matching writer.
// Ports:
//   rd_en_i      read port uses its operand
//   rd_addr_i    read port register address
//   src_we_i     per-source register-file write enable
//   src_waddr_i  per-source destination address, source s at [s*ADDR_W +: ADDR_W]
//   src_wdata_i  per-source result, source s at [s*DATA_W +: DATA_W]
//   src_late_i   per-source "result not yet valid" flag
//   hit_o        some source matches
//   late_o       the winning source is late
//   data_o       winning source result (0 when no hit)
module fwd_port_sel #(
  parameter int unsigned NUM_SRC  = 3,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                       rd_en_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  input  logic [NUM_SRC-1:0]         src_we_i,
  input  logic [NUM_SRC*ADDR_W-1:0]  src_waddr_i,
  input  logic [NUM_SRC*DATA_W-1:0]  src_wdata_i,
  input  logic [NUM_SRC-1:0]         src_late_i,
  output logic                       hit_o,
  output logic                       late_o,
  output logic [DATA_W-1:0]          data_o
);

  logic               zero_addr;
  logic [NUM_SRC-1:0] match;

  assign zero_addr = ZERO_REG && (rd_addr_i == '0);

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_match
    assign match[s] = rd_en_i & src_we_i[s] & ~zero_addr &
                      (src_waddr_i[s*ADDR_W +: ADDR_W] == rd_addr_i);
  end

  // Walk from oldest to youngest so the youngest match overwrites the others.
  always_comb begin
    hit_o  = 1'b0;
    late_o = 1'b0;
    data_o = '0;
    for (int s = NUM_SRC - 1; s >= 0; s--) begin
      if (match[s]) begin
        hit_o  = 1'b1;
        late_o = src_late_i[s];
        data_o = src_wdata_i[s*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/fwd_bypass_unit.sv
// ID-stage operand bypass unit.
// Serves NUM_RPORTS register-file read ports from NUM_SRC producer stages
// (index 0 youngest, NUM_SRC-1 the write-back stage), raises a load-use
// stall request, and registers per-port select/data for EX.
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   flush_i        pipeline flush
//   stall_i        stall bus (bit 2 ID, bit 3 EX; 1 = stop)
//   rd_en_i        per-port operand used
//   rd_addr_i      per-port address, port p at [p*ADDR_W +: ADDR_W]
//   src_we_i       per-source write enable
//   src_waddr_i    per-source destination address
//   src_wdata_i    per-source result
//   src_late_i     per-source result not yet valid
//   stallreq_o     load-use hazard (combinational)
//   fwd_sel_r_o    registered: port p takes fwd_data_r_o instead of the RF
//   fwd_data_r_o   registered forwarded operand per port
module fwd_bypass_unit
  import fwd_bypass_unit_pkg::*;
#(
  parameter int unsigned NUM_RPORTS = 2,
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STALL_W    = StallBusW,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [STALL_W-1:0]           stall_i,
  input  logic [NUM_RPORTS-1:0]        rd_en_i,
  input  logic [NUM_RPORTS*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_SRC-1:0]           src_we_i,
  input  logic [NUM_SRC*ADDR_W-1:0]    src_waddr_i,
  input  logic [NUM_SRC*DATA_W-1:0]    src_wdata_i,
  input  logic [NUM_SRC-1:0]           src_late_i,
  output logic                         stallreq_o,
  output logic [NUM_RPORTS-1:0]        fwd_sel_r_o,
  output logic [NUM_RPORTS*DATA_W-1:0] fwd_data_r_o
);

  localparam int unsigned WbIdx = NUM_SRC - 1;

  logic [NUM_RPORTS-1:0]        hit;
  logic [NUM_RPORTS-1:0]        late;
  logic [NUM_RPORTS*DATA_W-1:0] win_data;
  logic                         hazard;
  upd_mode_e                    mode;

  logic [NUM_RPORTS-1:0]        sel_d, sel_q;
  logic [NUM_RPORTS*DATA_W-1:0] data_d, data_q;
  logic [NUM_RPORTS*ADDR_W-1:0] addr_d, addr_q;
  logic [NUM_RPORTS-1:0]        en_d, en_q;

  logic                         wb_we;
  logic                         wb_late;
  logic [ADDR_W-1:0]            wb_addr;
  logic [DATA_W-1:0]            wb_data;

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
    fwd_port_sel #(
      .NUM_SRC  (NUM_SRC),
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .ZERO_REG (ZERO_REG)
    ) u_port_sel (
      .rd_en_i     (rd_en_i[p]),
      .rd_addr_i   (rd_addr_i[p*ADDR_W +: ADDR_W]),
      .src_we_i    (src_we_i),
      .src_waddr_i (src_waddr_i),
      .src_wdata_i (src_wdata_i),
      .src_late_i  (src_late_i),
      .hit_o       (hit[p]),
      .late_o      (late[p]),
      .data_o      (win_data[p*DATA_W +: DATA_W])
    );
  end

  // Only the winner's late flag counts, so an older late source shadowed by
  // a younger ready one never stalls.
  assign hazard     = |(hit & late);
  assign stallreq_o = hazard & ~rst_i;

  assign mode = upd_mode(rst_i, flush_i, stall_i[StallIdIdx], stall_i[StallExIdx]);

  assign wb_we   = src_we_i[WbIdx];
  assign wb_late = src_late_i[WbIdx];
  assign wb_addr = src_waddr_i[WbIdx*ADDR_W +: ADDR_W];
  assign wb_data = src_wdata_i[WbIdx*DATA_W +: DATA_W];

  always_comb begin
    sel_d  = sel_q;
    data_d = data_q;
    addr_d = addr_q;
    en_d   = en_q;
    unique case (mode)
      UpdClear: begin
        sel_d  = '0;
        data_d = '0;
        addr_d = '0;
        en_d   = '0;
      end
      UpdCapture: begin
        en_d   = rd_en_i;
        addr_d = rd_addr_i;
        // The instruction will not issue while a hazard is raised, so nothing
        // is forwarded for it; the ID stall then turns the next edge into a bubble.
        for (int p = 0; p < NUM_RPORTS; p++) begin
          sel_d[p] = hit[p] & ~late[p] & ~hazard;
          data_d[p*DATA_W +: DATA_W] = sel_d[p] ? win_data[p*DATA_W +: DATA_W] : '0;
        end
      end
      UpdHold: begin
        // The write-back result retires this cycle and will not be visible to
        // the held instruction via the RF read it already did.
        for (int p = 0; p < NUM_RPORTS; p++) begin
          if (en_q[p] && wb_we && !wb_late && (wb_addr == addr_q[p*ADDR_W +: ADDR_W]) &&
              !(ZERO_REG && (addr_q[p*ADDR_W +: ADDR_W] == '0))) begin
            sel_d[p]                   = 1'b1;
            data_d[p*DATA_W +: DATA_W] = wb_data;
          end
        end
      end
      default: begin
        sel_d = sel_q;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q  <= '0;
      data_q <= '0;
      addr_q <= '0;
      en_q   <= '0;
    end else begin
      sel_q  <= sel_d;
      data_q <= data_d;
      addr_q <= addr_d;
      en_q   <= en_d;
    end
  end

  assign fwd_sel_r_o  = sel_q;
  assign fwd_data_r_o = data_q;

endmodule

// File: tb/tb_fwd_bypass_unit.sv
module tb_fwd_bypass_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default build: 2 ports, 3 sources.
  logic        rst0, flush0;
  logic [5:0]  stall0;
  logic [1:0]  en0;
  logic [9:0]  addr0;
  logic [2:0]  we0, late0;
  logic [14:0] waddr0;
  logic [95:0] wdata0;
  logic        sr0;
  logic [1:0]  sel0;
  logic [63:0] data0;

  fwd_bypass_unit u_dut0 (
    .clk_i        (clk),
    .rst_i        (rst0),
    .flush_i      (flush0),
    .stall_i      (stall0),
    .rd_en_i      (en0),
    .rd_addr_i    (addr0),
    .src_we_i     (we0),
    .src_waddr_i  (waddr0),
    .src_wdata_i  (wdata0),
    .src_late_i   (late0),
    .stallreq_o   (sr0),
    .fwd_sel_r_o  (sel0),
    .fwd_data_r_o (data0)
  );

  // Wide build: 3 ports, 4 sources, random traffic.
  logic         rst1, flush1;
  logic [5:0]   stall1;
  logic [2:0]   en1;
  logic [14:0]  addr1;
  logic [3:0]   we1, late1;
  logic [19:0]  waddr1;
  logic [127:0] wdata1;
  logic         sr1;
  logic [2:0]   sel1;
  logic [95:0]  data1;

  fwd_bypass_unit #(
    .NUM_RPORTS (3),
    .NUM_SRC    (4)
  ) u_dut1 (
    .clk_i        (clk),
    .rst_i        (rst1),
    .flush_i      (flush1),
    .stall_i      (stall1),
    .rd_en_i      (en1),
    .rd_addr_i    (addr1),
    .src_we_i     (we1),
    .src_waddr_i  (waddr1),
    .src_wdata_i  (wdata1),
    .src_late_i   (late1),
    .stallreq_o   (sr1),
    .fwd_sel_r_o  (sel1),
    .fwd_data_r_o (data1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  en;
    logic [9:0]  addr;
    logic [2:0]  we;
    logic [14:0] waddr;
    logic [95:0] wdata;
    logic [2:0]  late;
    logic [5:0]  stall;
    logic        flush;
    logic        exp_sr;
    logic [1:0]  exp_sel;
    logic [63:0] exp_data;
  } vec_t;

  function automatic vec_t mk(logic [1:0] en, logic [9:0] addr, logic [2:0] we,
                              logic [14:0] waddr, logic [95:0] wdata, logic [2:0] late,
                              logic [5:0] stall, logic flush, logic exp_sr,
                              logic [1:0] exp_sel, logic [63:0] exp_data);
    vec_t v;
    v.en = en; v.addr = addr; v.we = we; v.waddr = waddr; v.wdata = wdata;
    v.late = late; v.stall = stall; v.flush = flush;
    v.exp_sr = exp_sr; v.exp_sel = exp_sel; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic drive0(input logic [1:0] en, input logic [9:0] addr, input logic [2:0] we,
                        input logic [14:0] waddr, input logic [95:0] wdata,
                        input logic [2:0] late, input logic [5:0] stall, input logic flush);
    @(negedge clk);
    en0 = en; addr0 = addr; we0 = we; waddr0 = waddr; wdata0 = wdata;
    late0 = late; stall0 = stall; flush0 = flush;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out0(input string tag, input logic [1:0] es, input logic [63:0] ed);
    chk({tag, "_sel"}, {30'd0, sel0}, {30'd0, es});
    chk({tag, "_data0"}, data0[31:0], ed[31:0]);
    chk({tag, "_data1"}, data0[63:32], ed[63:32]);
  endtask

  // Reference model for the wide build: spec rules over plain arrays.
  logic        m_en[3];
  logic [4:0]  m_addr[3];
  logic        m_we[4];
  logic [4:0]  m_waddr[4];
  logic [31:0] m_wdata[4];
  logic        m_late[4];
  logic        m_rst, m_flush;
  logic [5:0]  m_stall;
  logic        e_sel[3];
  logic [31:0] e_data[3];
  logic [4:0]  e_addr[3];
  logic        e_en[3];

  function automatic int winner(int p);
    if (!m_en[p] || m_addr[p] == 5'd0) return -1;
    for (int s = 0; s < 4; s++)
      if (m_we[s] && m_waddr[s] == m_addr[p]) return s;
    return -1;
  endfunction

  function automatic logic model_hazard();
    for (int p = 0; p < 3; p++) begin
      int w;
      w = winner(p);
      if (w >= 0 && m_late[w]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    logic hz;
    hz = model_hazard();
    if (m_rst || m_flush || (m_stall[2] && !m_stall[3])) begin
      for (int p = 0; p < 3; p++) begin
        e_sel[p] = 0; e_data[p] = 0; e_addr[p] = 0; e_en[p] = 0;
      end
    end else if (!m_stall[2]) begin
      for (int p = 0; p < 3; p++) begin
        int w;
        w = winner(p);
        e_en[p] = m_en[p];
        e_addr[p] = m_addr[p];
        e_sel[p] = (w >= 0) && !hz;
        e_data[p] = e_sel[p] ? m_wdata[w] : 32'd0;
      end
    end else begin
      for (int p = 0; p < 3; p++)
        if (e_en[p] && m_we[3] && !m_late[3] && m_waddr[3] == e_addr[p] && e_addr[p] != 0) begin
          e_sel[p] = 1;
          e_data[p] = m_wdata[3];
        end
    end
  endtask

  task automatic drive1();
    rst1 = m_rst; flush1 = m_flush; stall1 = m_stall;
    for (int p = 0; p < 3; p++) begin
      en1[p] = m_en[p];
      addr1[p*5 +: 5] = m_addr[p];
    end
    for (int s = 0; s < 4; s++) begin
      we1[s] = m_we[s];
      late1[s] = m_late[s];
      waddr1[s*5 +: 5] = m_waddr[s];
      wdata1[s*32 +: 32] = m_wdata[s];
    end
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = mk(2'b01, {5'd0, 5'd8}, 3'b011, {5'd0, 5'd8, 5'd8},
                  {32'h0, 32'h22, 32'h11}, 3'b000, 6'b0, 1'b0, 1'b0, 2'b01, {32'h0, 32'h11});
    vecs[1]  = mk(2'b10, {5'd9, 5'd0}, 3'b001, {5'd0, 5'd0, 5'd9},
                  {32'h0, 32'h0, 32'h99}, 3'b001, 6'b0, 1'b0, 1'b1, 2'b00, 64'h0);
    vecs[2]  = mk(2'b01, {5'd0, 5'd0}, 3'b001, {5'd0, 5'd0, 5'd0},
                  {32'h0, 32'h0, 32'hFF}, 3'b000, 6'b0, 1'b0, 1'b0, 2'b00, 64'h0);
    vecs[3]  = mk(2'b11, {5'd5, 5'd5}, 3'b010, {5'd0, 5'd5, 5'd0},
                  {32'h0, 32'h55, 32'h0}, 3'b000, 6'b0, 1'b0, 1'b0, 2'b11, {32'h55, 32'h55});
    vecs[4]  = mk(2'b01, {5'd0, 5'd6}, 3'b011, {5'd0, 5'd6, 5'd6},
                  {32'h0, 32'hAA, 32'h66}, 3'b010, 6'b0, 1'b0, 1'b0, 2'b01, {32'h0, 32'h66});
    vecs[5]  = mk(2'b10, {5'd7, 5'd3}, 3'b100, {5'd7, 5'd0, 5'd0},
                  {32'h77, 32'h0, 32'h0}, 3'b000, 6'b0, 1'b0, 1'b0, 2'b10, {32'h77, 32'h0});
    vecs[6]  = mk(2'b00, {5'd7, 5'd7}, 3'b100, {5'd7, 5'd0, 5'd0},
                  {32'h77, 32'h0, 32'h0}, 3'b000, 6'b0, 1'b0, 1'b0, 2'b00, 64'h0);
    vecs[7]  = mk(2'b11, {5'd3, 5'd3}, 3'b001, {5'd0, 5'd0, 5'd3},
                  {32'h0, 32'h0, 32'h33}, 3'b000, 6'b000100, 1'b0, 1'b0, 2'b00, 64'h0);
    vecs[8]  = mk(2'b11, {5'd5, 5'd5}, 3'b010, {5'd0, 5'd5, 5'd0},
                  {32'h0, 32'h55, 32'h0}, 3'b000, 6'b0, 1'b1, 1'b0, 2'b00, 64'h0);
    vecs[9]  = mk(2'b11, {5'd2, 5'd1}, 3'b011, {5'd0, 5'd2, 5'd1},
                  {32'h0, 32'hB2, 32'hA1}, 3'b001, 6'b0, 1'b0, 1'b1, 2'b00, 64'h0);
    vecs[10] = mk(2'b01, {5'd0, 5'd8}, 3'b011, {5'd0, 5'd8, 5'd8},
                  {32'h0, 32'h22, 32'h11}, 3'b000, 6'b001000, 1'b0, 1'b0, 2'b01,
                  {32'h0, 32'h11});
    vecs[11] = mk(2'b01, {5'd0, 5'd12}, 3'b110, {5'd12, 5'd12, 5'd0},
                  {32'hC2, 32'hC1, 32'h0}, 3'b100, 6'b0, 1'b0, 1'b0, 2'b01, {32'h0, 32'hC1});

    // Idle the wide build in reset while the default build is exercised.
    m_rst = 1; m_flush = 0; m_stall = 0;
    for (int p = 0; p < 3; p++) begin m_en[p] = 0; m_addr[p] = 0; end
    for (int s = 0; s < 4; s++) begin
      m_we[s] = 0; m_waddr[s] = 0; m_wdata[s] = 0; m_late[s] = 0;
    end
    drive1();

    // Reset: stallreq held low even with a late match present.
    rst0 = 1'b1;
    drive0(2'b01, {5'd0, 5'd8}, 3'b001, {5'd0, 5'd0, 5'd8}, 96'h1, 3'b001, 6'b0, 1'b0);
    #1 chk("rst_stallreq", {31'd0, sr0}, 32'd0);
    tick();
    chk_out0("reset", 2'b00, 64'h0);
    @(negedge clk);
    rst0 = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive0(vecs[i].en, vecs[i].addr, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
             vecs[i].late, vecs[i].stall, vecs[i].flush);
      #1 chk($sformatf("vec%0d_stallreq", i), {31'd0, sr0}, {31'd0, vecs[i].exp_sr});
      tick();
      chk_out0($sformatf("vec%0d", i), vecs[i].exp_sel, vecs[i].exp_data);
    end

    // Bubble into EX clears a live forward.
    drive0(vecs[0].en, vecs[0].addr, vecs[0].we, vecs[0].waddr, vecs[0].wdata, 3'b0, 6'b0, 1'b0);
    tick();
    chk_out0("bub_pre", 2'b01, {32'h0, 32'h11});
    drive0(vecs[0].en, vecs[0].addr, vecs[0].we, vecs[0].waddr, vecs[0].wdata, 3'b0,
           6'b000100, 1'b0);
    tick();
    chk_out0("bubble", 2'b00, 64'h0);

    // Flush clears a live forward.
    drive0(vecs[0].en, vecs[0].addr, vecs[0].we, vecs[0].waddr, vecs[0].wdata, 3'b0, 6'b0, 1'b0);
    tick();
    drive0(vecs[0].en, vecs[0].addr, vecs[0].we, vecs[0].waddr, vecs[0].wdata, 3'b0, 6'b0, 1'b1);
    #1 chk("flush_stallreq", {31'd0, sr0}, 32'd0);
    tick();
    chk_out0("flush", 2'b00, 64'h0);

    // Hold: keep the captured forward while ID/EX stopped and inputs change.
    drive0(vecs[0].en, vecs[0].addr, vecs[0].we, vecs[0].waddr, vecs[0].wdata, 3'b0, 6'b0, 1'b0);
    tick();
    drive0(2'b11, {5'd3, 5'd3}, 3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h33}, 3'b0,
           6'b001100, 1'b0);
    tick();
    chk_out0("hold_keep", 2'b01, {32'h0, 32'h11});

    // Hold refresh: port0 latched addr 4, write-back of 4 arrives while held.
    drive0(2'b01, {5'd0, 5'd4}, 3'b000, 15'h0, 96'h0, 3'b0, 6'b0, 1'b0);
    tick();
    chk_out0("refresh_pre", 2'b00, 64'h0);
    drive0(2'b11, {5'd1, 5'd1}, 3'b101, {5'd4, 5'd0, 5'd1}, {32'hABCD, 32'h0, 32'h5}, 3'b0,
           6'b001100, 1'b0);
    tick();
    chk_out0("refresh", 2'b01, {32'h0, 32'hABCD});
    drive0(2'b11, {5'd1, 5'd1}, 3'b100, {5'd4, 5'd0, 5'd0}, {32'h1234, 32'h0, 32'h0}, 3'b100,
           6'b001100, 1'b0);
    tick();
    chk_out0("refresh_late", 2'b01, {32'h0, 32'hABCD});

    // Reset in the middle of a hold with a late match on the inputs.
    @(negedge clk);
    rst0 = 1'b1;
    en0 = 2'b01; addr0 = {5'd0, 5'd9}; we0 = 3'b001; waddr0 = {5'd0, 5'd0, 5'd9};
    late0 = 3'b001; stall0 = 6'b001100; flush0 = 1'b0;
    #1 chk("rst_hold_stallreq", {31'd0, sr0}, 32'd0);
    tick();
    chk_out0("rst_hold", 2'b00, 64'h0);
    @(negedge clk);
    rst0 = 1'b0;

    // Wide build against the reference model.
    for (int p = 0; p < 3; p++) begin e_sel[p] = 0; e_data[p] = 0; e_addr[p] = 0; e_en[p] = 0; end
    tick();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("rnd%0d_sel%0d", cyc, p), {31'd0, sel1[p]}, {31'd0, e_sel[p]});
        chk($sformatf("rnd%0d_data%0d", cyc, p), data1[p*32 +: 32], e_data[p]);
      end
      m_rst = ($urandom_range(0, 63) == 0);
      m_flush = ($urandom_range(0, 31) == 0);
      m_stall = 6'($urandom);
      for (int p = 0; p < 3; p++) begin
        m_en[p] = ($urandom_range(0, 3) != 0);
        m_addr[p] = 5'($urandom_range(0, 3));
      end
      for (int s = 0; s < 4; s++) begin
        m_we[s] = $urandom_range(0, 1) == 1;
        m_waddr[s] = 5'($urandom_range(0, 3));
        m_wdata[s] = $urandom;
        m_late[s] = ($urandom_range(0, 3) == 0);
      end
      drive1();
      #1 chk($sformatf("rnd%0d_stallreq", cyc), {31'd0, sr1},
             {31'd0, model_hazard() & ~m_rst});
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
